// File: rtl/adder_seq_arb.sv
// adder_seq_arb: two-requester arbiter feeding a W-bit add through one
// shared external 12-bit adder slice, one slice per cycle, LSB slice first.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0_*/req1_*               valid/ready handshake and W-bit operands per requester
//   add_in / add_out            interleaved A/B slice to the adder, 13-bit result back
//   res_valid/res_ready         result handshake
//   res_sum/res_cout/res_id     W-bit sum, carry-out, owning requester
module adder_seq_arb #(
    parameter int unsigned NBEATS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [12*NBEATS-1:0]   req0_a,
    input  logic [12*NBEATS-1:0]   req0_b,
    input  logic [12*NBEATS-1:0]   req1_a,
    input  logic [12*NBEATS-1:0]   req1_b,
    output logic [23:0]            add_in,
    input  logic [12:0]            add_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [12*NBEATS-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id
);
    localparam int unsigned W  = 12 * NBEATS;
    localparam int unsigned SW = 12;
    localparam int unsigned BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [BW-1:0]   beat_q;
    logic            carry_q;
    logic            last_grant_q;
    logic            id_q;

    logic            grant_c;
    logic            accept_c;
    logic [SW-1:0]   a_slice_c;
    logic [SW-1:0]   b_slice_c;
    logic [SW-1:0]   slice_sum_d;
    logic            carry_d;

    // Round-robin pick: a lone requester wins, contention goes to the one not served last
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    // Readies are masked during reset so nothing is accepted on a reset edge
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant_c;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  grant_c;
    assign accept_c   = req0_ready || req1_ready;

    assign a_slice_c = a_q[SW*32'(beat_q) +: SW];
    assign b_slice_c = b_q[SW*32'(beat_q) +: SW];

    // Drive the current slice bit-interleaved, A on even bits, B on odd bits
    always_comb begin
        add_in = '0;
        if (!rst && (state_q == RUN)) begin
            for (int k = 0; k < SW; k++) begin
                add_in[2*k]   = a_slice_c[k];
                add_in[2*k+1] = b_slice_c[k];
            end
        end
    end

    // The slice has no carry-in, so the running carry is added here and
    // propagates out when the slice sum was all ones
    assign slice_sum_d = add_out[SW-1:0] + SW'(carry_q);
    assign carry_d     = add_out[SW] | ((&add_out[SW-1:0]) & carry_q);

    // Controller, datapath registers and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            beat_q       <= '0;
            carry_q      <= 1'b0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_cout     <= 1'b0;
            res_id       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q          <= grant_c ? req1_a : req0_a;
                        b_q          <= grant_c ? req1_b : req0_b;
                        id_q         <= grant_c;
                        last_grant_q <= grant_c;
                        beat_q       <= '0;
                        carry_q      <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    res_sum[SW*32'(beat_q) +: SW] <= slice_sum_d;
                    carry_q <= carry_d;
                    beat_q  <= beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_q    <= '0;
                        res_cout  <= carry_d;
                        res_id    <= id_q;
                        res_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_arb.sv
// Directed bench for adder_seq_arb with a behavioral model of the 12-bit
// adder slice closing the add_in/add_out loop.
module tb_adder_seq_arb;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 12 * NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [23:0]   add_in;
    logic [12:0]   add_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    logic          res_id;

    int n_vec = 0;
    int n_err = 0;

    adder_seq_arb #(.NBEATS(NB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .add_in(add_in), .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    always #5 clk = ~clk;

    // Shared adder slice model: de-interleave and add, no carry-in
    logic [11:0] sa, sb;
    always_comb begin
        sa = '0;
        sb = '0;
        for (int k = 0; k < 12; k++) begin
            sa[k] = add_in[2*k];
            sb[k] = add_in[2*k+1];
        end
        add_out = {1'b0, sa} + {1'b0, sb};
    end

    function automatic logic [23:0] ilv(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        for (int k = 0; k < 12; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

    // Advance one cycle at a time until res_valid, reporting cycles taken
    task automatic wait_res(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk); #1;
            n++;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got %b exp 0", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got %b exp 0", req1_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        n_vec++; if (res_sum !== '0) begin n_err++; $display("FAIL rst_res_sum got %h exp 0", res_sum); end
        n_vec++; if (res_cout !== 1'b0 || res_id !== 1'b0) begin n_err++; $display("FAIL rst_cout_id got %b%b exp 00", res_cout, res_id); end
        n_vec++; if (add_in !== 24'h0) begin n_err++; $display("FAIL rst_add_in got %h exp 0", add_in); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [W-1:0] a, b;
        a = 48'h0000_0000_0001; b = 48'h0000_0000_0002;
        @(negedge clk);
        rst = 1'b0; req0_a = a; req0_b = b; req0_valid = 1'b1;
        #1;
        n_vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL single_grant got %b%b exp 10", req0_ready, req1_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); req0_valid = 1'b0; #1;
            n_vec++; if (add_in !== ilv(a[12*(c-1) +: 12], b[12*(c-1) +: 12])) begin n_err++; $display("FAIL single_add_in beat %0d got %h exp %h", c-1, add_in, ilv(a[12*(c-1) +: 12], b[12*(c-1) +: 12])); end
            n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid t+%0d got %b exp 0", c, res_valid); end
        end
        @(negedge clk); #1;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_t5 got %b exp 1", res_valid); end
        n_vec++; if (res_sum !== 48'h3 || res_cout !== 1'b0 || res_id !== 1'b0) begin n_err++; $display("FAIL single_result got %h/%b/%b exp 3/0/0", res_sum, res_cout, res_id); end
        n_vec++; if (add_in !== 24'h0) begin n_err++; $display("FAIL single_done_add_in got %h exp 0", add_in); end
        res_ready = 1'b1;
        @(negedge clk); #1;
        res_ready = 1'b0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_release got %b exp 0", res_valid); end
    endtask

    task automatic test_ripple();
        logic [W-1:0] a, b;
        a = 48'hFFFF_FFFF_FFFF; b = 48'h0000_0000_0001;
        @(negedge clk);
        req0_a = a; req0_b = b; req0_valid = 1'b1;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL ripple_grant got %b exp 1", req0_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); req0_valid = 1'b0; #1;
            n_vec++; if (add_in !== ilv(a[12*(c-1) +: 12], b[12*(c-1) +: 12])) begin n_err++; $display("FAIL ripple_add_in beat %0d got %h exp %h", c-1, add_in, ilv(a[12*(c-1) +: 12], b[12*(c-1) +: 12])); end
        end
        @(negedge clk); #1;
        n_vec++; if (res_valid !== 1'b1 || res_sum !== 48'h0 || res_cout !== 1'b1) begin n_err++; $display("FAIL ripple_result got v%b %h/%b exp v1 0/1", res_valid, res_sum, res_cout); end
        res_ready = 1'b1;
        @(negedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_contention();
        int g_id[4], g_cyc[4], r_id[4], r_cyc[4];
        logic [W-1:0] r_sum[4];
        logic r_cout[4];
        int ng, nr;
        ng = 0; nr = 0;
        @(negedge clk);
        rst = 1'b1; res_ready = 1'b1;
        req0_a = 48'h8000_0000_0000; req0_b = 48'h8000_0000_0000;
        req1_a = 48'h0000_0FFF_F000; req1_b = 48'h0000_0000_1000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (ng < 4 && req0_ready) begin g_id[ng] = 0; g_cyc[ng] = cyc; ng++; end
            else if (ng < 4 && req1_ready) begin g_id[ng] = 1; g_cyc[ng] = cyc; ng++; end
            if (res_valid && nr < 4) begin
                r_id[nr] = int'(res_id); r_cyc[nr] = cyc; r_sum[nr] = res_sum; r_cout[nr] = res_cout; nr++;
            end
            if (nr == 4) break;
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        n_vec++; if (ng != 4 || nr != 4) begin n_err++; $display("FAIL cont_count got %0d grants %0d results exp 4/4", ng, nr); end
        if (ng == 4 && nr == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (g_id[i] != i % 2) begin n_err++; $display("FAIL cont_grant%0d got %0d exp %0d", i, g_id[i], i % 2); end
                n_vec++; if (r_id[i] != i % 2) begin n_err++; $display("FAIL cont_res_id%0d got %0d exp %0d", i, r_id[i], i % 2); end
                if (i % 2 == 0) begin
                    n_vec++; if (r_sum[i] !== 48'h0 || r_cout[i] !== 1'b1) begin n_err++; $display("FAIL cont_sum%0d got %h/%b exp 0/1", i, r_sum[i], r_cout[i]); end
                end else begin
                    n_vec++; if (r_sum[i] !== 48'h0000_1000_0000 || r_cout[i] !== 1'b0) begin n_err++; $display("FAIL cont_sum%0d got %h/%b exp 000010000000/0", i, r_sum[i], r_cout[i]); end
                end
            end
            n_vec++; if (g_cyc[0] != 0 || r_cyc[0] != 5) begin n_err++; $display("FAIL cont_latency got grant %0d result %0d exp 0/5", g_cyc[0], r_cyc[0]); end
            n_vec++; if (g_cyc[1] - g_cyc[0] != 6) begin n_err++; $display("FAIL cont_period got %0d exp 6", g_cyc[1] - g_cyc[0]); end
        end
    endtask

    task automatic test_backpressure();
        int n; bit ok;
        @(negedge clk);
        req1_a = 48'h5; req1_b = 48'h7; req1_valid = 1'b1; res_ready = 1'b0;
        #1;
        n_vec++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_grant got %b%b exp 01", req0_ready, req1_ready); end
        wait_res(20, n, ok);
        n_vec++; if (!ok || n != 5) begin n_err++; $display("FAIL bp_latency got ok=%0d n=%0d exp 1/5", ok, n); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (res_valid !== 1'b1 || res_sum !== 48'hC || res_cout !== 1'b0 || res_id !== 1'b1) begin n_err++; $display("FAIL bp_hold c%0d got v%b %h/%b/%b exp v1 c/0/1", i, res_valid, res_sum, res_cout, res_id); end
            n_vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || add_in !== 24'h0) begin n_err++; $display("FAIL bp_quiet c%0d got rdy %b%b add_in %h exp 00 0", i, req0_ready, req1_ready, add_in); end
            @(negedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        #1;
        n_vec++; if (res_valid !== 1'b0 || res_sum !== 48'hC || res_id !== 1'b1) begin n_err++; $display("FAIL bp_release got v%b %h/%b exp v0 c/1", res_valid, res_sum, res_id); end
        req0_valid = 1'b1; #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready got %b exp 1", req0_ready); end
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b;
        int n; bit ok;
        a = 48'h0123_4567_89AB; b = 48'h1111_1111_1111;
        @(negedge clk);
        req0_a = a; req0_b = b; req0_valid = 1'b1;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_grant got %b exp 1", req0_ready); end
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_vec++; if (add_in !== ilv(a[35:24], b[35:24])) begin n_err++; $display("FAIL mid_beat2 got %h exp %h", add_in, ilv(a[35:24], b[35:24])); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        n_vec++; if (res_valid !== 1'b0 || add_in !== 24'h0) begin n_err++; $display("FAIL mid_after_rst got v%b add_in %h exp v0 0", res_valid, add_in); end
        req1_valid = 1'b1; req0_valid = 1'b1; #1;
        n_vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL mid_first_grant got %b%b exp 10", req0_ready, req1_ready); end
        wait_res(20, n, ok);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_vec++; if (!ok || n != 5) begin n_err++; $display("FAIL mid_latency got ok=%0d n=%0d exp 1/5", ok, n); end
        n_vec++; if (res_sum !== 48'h1234_5678_9ABC || res_cout !== 1'b0 || res_id !== 1'b0) begin n_err++; $display("FAIL mid_result got %h/%b/%b exp 123456789abc/0/0", res_sum, res_cout, res_id); end
        res_ready = 1'b1;
        @(negedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ripple();
        test_contention();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_seq_arb.md
ADDER_SEQ_ARB -- requirements
Module: adder_seq_arb

Interface
REQ-001 Parameter: NBEATS, default 4, number of 12-bit slices per operation; operand width W = 12*NBEATS.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  operation from requester 0/1 is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  W each  operands of requester 0/1.
REQ-007 add_in  output  24  drive to the shared 12-bit adder slice; bit 2k = A slice bit k, bit 2k+1 = B slice bit k.
REQ-008 add_out  input  13  result from the slice; [11:0] sum, [12] carry-out; purely combinational from add_in, no carry-in.
REQ-009 res_valid  output  1  result held and valid.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_sum  output  W  sum bits of the W-bit add.
REQ-012 res_cout  output  1  carry-out of the W-bit add.
REQ-013 res_id  output  1  index of the requester that owns the result.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 In IDLE, grant: if exactly one reqN_valid is high, grant N; if both are high, grant the requester other than last_grant.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-017 On acceptance (valid&ready), the block SHALL latch a, b and the id, set last_grant=id, clear beat=0, clear carry=0, and go to RUN.
REQ-018 In RUN, add_in SHALL carry slice beat of the latched A/B (bits 12*beat+11 : 12*beat) in the interleaved order of REQ-007.
REQ-019 Carry-in SHALL be applied inside the block: slice_sum = add_out[11:0] + carry (12-bit wrap); next carry = add_out[12] | (add_out[11:0]==12'hFFF & carry).
REQ-020 Each RUN cycle SHALL register slice_sum into res_sum[12*beat+11:12*beat] and update carry; beat increments by 1.
REQ-021 After the beat NBEATS-1 cycle, the FSM SHALL go to DONE; res_cout = final carry.
REQ-022 Latency: an operation accepted in cycle t SHALL have res_valid=1 from cycle t+1+NBEATS (t+5 for NBEATS=4).
REQ-023 In DONE, res_valid=1; res_sum, res_cout and res_id SHALL be stable until res_valid&res_ready.
REQ-024 On res_valid&res_ready, the FSM SHALL return to IDLE in the next cycle; no acceptance occurs in DONE (minimum 2+NBEATS cycles per operation).
REQ-025 add_in SHALL be 0 in IDLE and DONE.
REQ-026 res_valid SHALL be 0 in IDLE and RUN; res_sum/res_cout/res_id SHALL keep their last values outside DONE.
REQ-027 Requester valid deasserting while not granted SHALL have no effect; operands are sampled only on acceptance.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, beat=0, carry=0, last_grant=1 (requester 0 wins the first contention), res_valid=0, res_sum=0, res_cout=0, res_id=0, add_in=0, both readies 0 in that cycle.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered; the first grant after reset follows REQ-015 with last_grant=1.

Verification
REQ-030 Single op: req0 a=48'h0000_0000_0001, b=48'h0000_0000_0002 -> res_valid at t+5, res_sum=3, res_cout=0, res_id=0.
REQ-031 Full carry ripple: a=48'hFFFF_FFFF_FFFF, b=1 -> res_sum=0, res_cout=1; add_in shows slices 0..3 on cycles t+1..t+4.
REQ-032 Contention: both valid from reset release, held -> grants alternate 0,1,0,1; each result carries the matching res_id and correct sum (a=48'h800000000000, b=48'h800000000000 -> sum 0, cout 1).
REQ-033 Backpressure: res_ready=0 for 10 cycles in DONE -> outputs stable, both readies 0, no new acceptance; res_ready=1 -> IDLE the next cycle.
REQ-034 Reset mid-RUN at beat 2 -> next cycle IDLE, res_valid=0, add_in=0; a pending req1 plus a new req0 -> req0 granted first.
